dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. It replaces the zero-latency combinational data memory with a handshaked, multi-cycle slave.
- It accepts one load/store request at a time over a valid/ready request channel and services it after a configurable latency. It returns the result over a valid/ready response channel.
- Sits between the core's load/store path and the word-addressed data storage. The storage array is internal to this block.

Parameters:
- ADDR_W, 10, word-address bits; storage depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i enables byte lane [8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester can take the response
- rsp_rdata  output  32  load data; 0 for stores
- rsp_err  output  1  access error flag, qualified by rsp_valid

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter is cleared.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture we/addr/wdata/be and load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1, else to WAIT.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter is 1, go to RESP next cycle.
  - A request accepted in cycle N yields rsp_valid in cycle N+LATENCY.
- Entry into RESP (the same edge that raises rsp_valid):
  - The access executes once.
  - Load: rsp_rdata = mem[word index].
  - Store: mem[word index] is updated only on lanes with be=1; rsp_rdata=0.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, return to IDLE and clear rsp_valid.
- No overlap: a new request cannot be accepted in the response-handshake cycle. Peak throughput is one access per LATENCY+1 cycles.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so the address space aliases (wraps) every 2**(ADDR_W+2) bytes.
- req_addr[1:0] handling is defined under Optional Feature.
- Store with req_be=4'b0000: no storage change; a normal response is still returned.
- A load following a store to the same word returns the updated data. Accesses are strictly ordered.
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- Reset mid-operation:
  - A store in WAIT is discarded with no storage write.
  - A response pending in RESP is dropped.
  - A store already executed on RESP entry stays in storage.
- req_valid held high while req_ready=0 has no effect. The requester must keep the request stable until it is accepted.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0] != 2'b00 is flagged as misaligned.
  - It follows the same latency and handshake as a normal request.
  - On RESP it returns rsp_err=1 and rsp_rdata=0, and a store performs no write.
  - Aligned requests return rsp_err=0.
- Undefined: req_addr[1:0] is ignored, and rsp_err is tied to 0.

Test Plan:
- Reset check: rst low for 3 cycles, then high → req_ready=1, rsp_valid=0, rsp_rdata=0 during and immediately after reset.
- Store/load, LATENCY=2, rsp_ready tied 1:
  - store addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted in cycle N → rsp_valid in N+2 with rsp_rdata=0.
  - load of 0x10 → rsp_rdata=0xDEADBEEF.
- Byte enables: over 0xDEADBEEF at 0x10, store wdata 0x11223344 with be 4'b0101 → subsequent load of 0x10 returns 0xDE22BE44.
- Backpressure: load accepted, rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stay stable, req_ready stays 0; rsp_ready=1 → handshake, then req_ready=1 the next cycle.
- Aliasing (ADDR_W=10): store 0xA5A5A5A5 to 0x1004 → load of 0x0004 returns 0xA5A5A5A5.
- Reset mid-operation: store to 0x20 accepted, rst asserted in the WAIT cycle → a later load of 0x20 returns the prior contents.
- Misaligned access (DMEM_ALIGN_CHECK_EN defined): store to 0x22 → rsp_err=1, and a later load of 0x20 is unchanged. With the macro undefined, the same store writes word 0x20 and rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory slave with internal storage.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W+1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;

    logic              accept;
    logic              acc_fire;
    logic              acc_we;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;
    logic [31:0]       rd_word;

    logic [31:0] mem [DEPTH];

    // Access executes on RESP entry; with LATENCY==1 that is straight
    // from IDLE, so the live request is used instead of the captured copy.
    assign acc_we    = (state == IDLE) ? req_we : cap_we;
    assign acc_addr  = (state == IDLE) ? req_addr[ADDR_W+1:0] : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_be    = (state == IDLE) ? req_be : cap_be;
    assign acc_idx   = acc_addr[ADDR_W+1:2];
    assign rd_word   = mem[acc_idx];

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_err = |acc_addr[1:0];
    logic unused_addr;
    assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};
`else
    assign acc_err = 1'b0;
    logic unused_addr;
    assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2], acc_addr[1:0]};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        acc_fire = (state != RESP) && (state_nx == RESP);
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= 4'(LATENCY - 1);
                cap_we    <= req_we;
                cap_addr  <= req_addr[ADDR_W+1:0];
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (acc_fire) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_we || acc_err) ? 32'd0 : rd_word;
            end else if (rsp_valid && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Lane-masked store; storage is never reset.
    always_ff @(posedge clk) begin
        if (acc_fire && rst && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule
